// File: rtl/hrm_io_fifo_pkg.sv
// hrm_io_fifo_pkg: default INBOX/OUTBOX channel geometry shared by the CPU and benches.
package hrm_io_fifo_pkg;
    localparam int IO_WIDTH      = 8;
    localparam int IO_DEPTH_LOG2 = 5;
endpackage

// File: rtl/hrm_io_fifo_mem.sv
// hrm_io_fifo_mem: FIFO storage array, synchronous write and asynchronous read (distributed RAM).
module hrm_io_fifo_mem
    import hrm_io_fifo_pkg::*;
#(
    parameter int WIDTH      = IO_WIDTH,
    parameter int DEPTH_LOG2 = IO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/hrm_io_fifo.sv
// hrm_io_fifo: first-word fall-through byte FIFO for the CPU INBOX/OUTBOX channels.
// Define HRM_IO_FIFO_ERR_EN to add sticky overflow/underflow flags (o_ovf, o_udf).
module hrm_io_fifo
    import hrm_io_fifo_pkg::*;
#(
    parameter int WIDTH      = IO_WIDTH,
    parameter int DEPTH_LOG2 = IO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_wr,
    input  logic [WIDTH-1:0]      i_data,
    output logic                  o_full,
    input  logic                  i_rd,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_empty,
`ifdef HRM_IO_FIFO_ERR_EN
    output logic                  o_ovf,
    output logic                  o_udf,
`endif
    output logic [DEPTH_LOG2:0]   o_count
);
    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic wr_ok, rd_ok;
    // Accept decisions use the registered flags, so a push into a full FIFO is dropped even when a pop frees space.
    assign wr_ok = i_wr && !o_full;
    assign rd_ok = i_rd && !o_empty;
    assign wr_n  = wr_ptr + {{DEPTH_LOG2{1'b0}}, wr_ok};
    assign rd_n  = rd_ptr + {{DEPTH_LOG2{1'b0}}, rd_ok};
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_empty <= 1'b1;
            o_full  <= 1'b0;
        end else begin
            wr_ptr  <= wr_n;
            rd_ptr  <= rd_n;
            o_count <= wr_n - rd_n;
            o_empty <= wr_n == rd_n;
            o_full  <= (wr_n[DEPTH_LOG2-1:0] == rd_n[DEPTH_LOG2-1:0]) && (wr_n[DEPTH_LOG2] != rd_n[DEPTH_LOG2]);
        end
    end
`ifdef HRM_IO_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
            o_udf <= 1'b0;
        end else begin
            if (i_wr && o_full) o_ovf <= 1'b1;
            if (i_rd && o_empty) o_udf <= 1'b1;
        end
    end
`endif
    hrm_io_fifo_mem #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (i_data),
        .raddr (rd_ptr[DEPTH_LOG2-1:0]),
        .rdata (o_data)
    );
endmodule

// File: tb/tb_hrm_io_fifo.sv
// tb_hrm_io_fifo: directed self-checking bench for hrm_io_fifo (32 x 8 default geometry).
module tb_hrm_io_fifo;
    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_wr = 1'b0;
    logic       i_rd = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       o_full, o_empty;
    logic [7:0] o_data;
    logic [5:0] o_count;
`ifdef HRM_IO_FIFO_ERR_EN
    logic       o_ovf, o_udf;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hrm_io_fifo dut (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_wr    (i_wr),
        .i_data  (i_data),
        .o_full  (o_full),
        .i_rd    (i_rd),
        .o_data  (o_data),
        .o_empty (o_empty),
`ifdef HRM_IO_FIFO_ERR_EN
        .o_ovf   (o_ovf),
        .o_udf   (o_udf),
`endif
        .o_count (o_count)
    );

    // One clock with the given strobes; outputs are then sampled 1ns after the edge.
    task automatic cyc(input logic wr, input logic [7:0] d, input logic rd);
        i_wr = wr;
        i_data = d;
        i_rd = rd;
        @(posedge clk);
        #1;
        i_wr = 1'b0;
        i_rd = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        cyc(1'b1, 8'hFF, 1'b1);
        cyc(1'b1, 8'hFE, 1'b0);
        i_rst = 1'b0;
        n_chk++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", o_empty); end
        n_chk++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", o_full); end
        n_chk++; if (o_count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", o_count); end
`ifdef HRM_IO_FIFO_ERR_EN
        n_chk++; if ({o_ovf, o_udf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {o_ovf, o_udf}); end
`endif
    endtask

    task automatic test_push_pop;
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        cyc(1'b1, 8'h11, 1'b0);
        n_chk++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL first_push_empty got %b want 0", o_empty); end
        n_chk++; if (o_data !== 8'h11) begin n_fail++; $display("FAIL first_push_data got %h want 11", o_data); end
        cyc(1'b1, 8'h22, 1'b0);
        cyc(1'b1, 8'h33, 1'b0);
        n_chk++; if (o_count !== 6'd3) begin n_fail++; $display("FAIL push3_count got %0d want 3", o_count); end
        n_chk++; if (o_data !== 8'h11) begin n_fail++; $display("FAIL push3_head got %h want 11", o_data); end
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (o_data !== exp_d[k]) begin n_fail++; $display("FAIL pop_order[%0d] got %h want %h", k, o_data, exp_d[k]); end
            cyc(1'b0, 8'h00, 1'b1);
        end
        n_chk++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL pop3_empty got %b want 1", o_empty); end
        n_chk++; if (o_count !== 6'd0) begin n_fail++; $display("FAIL pop3_count got %0d want 0", o_count); end
    endtask

    task automatic test_full;
        for (int k = 0; k < 32; k++) cyc(1'b1, 8'(k), 1'b0);
        n_chk++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got %b want 1", o_full); end
        n_chk++; if (o_count !== 6'd32) begin n_fail++; $display("FAIL full_count got %0d want 32", o_count); end
        cyc(1'b1, 8'hAA, 1'b0);
        n_chk++; if (o_count !== 6'd32) begin n_fail++; $display("FAIL ovf_push_count got %0d want 32", o_count); end
`ifdef HRM_IO_FIFO_ERR_EN
        n_chk++; if (o_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", o_ovf); end
`endif
        for (int k = 0; k < 32; k++) begin
            n_chk++; if (o_data !== 8'(k)) begin n_fail++; $display("FAIL full_drain[%0d] got %h want %h", k, o_data, 8'(k)); end
            cyc(1'b0, 8'h00, 1'b1);
        end
        n_chk++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty got %b want 1", o_empty); end
    endtask

    task automatic test_full_push_pop;
        for (int k = 0; k < 32; k++) cyc(1'b1, 8'(k), 1'b0);
        cyc(1'b1, 8'h55, 1'b1);
        n_chk++; if (o_count !== 6'd31) begin n_fail++; $display("FAIL fullpp_count got %0d want 31", o_count); end
        n_chk++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL fullpp_full got %b want 0", o_full); end
        n_chk++; if (o_data !== 8'h01) begin n_fail++; $display("FAIL fullpp_head got %h want 01", o_data); end
        for (int k = 0; k < 15; k++) cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h99, 1'b1);
        n_chk++; if (o_count !== 6'd16) begin n_fail++; $display("FAIL halfpp_count got %0d want 16", o_count); end
        n_chk++; if (o_data !== 8'h11) begin n_fail++; $display("FAIL halfpp_head got %h want 11", o_data); end
        for (int k = 0; k < 16; k++) begin
            logic [7:0] e;
            e = (k < 15) ? 8'(17 + k) : 8'h99;
            n_chk++; if (o_data !== e) begin n_fail++; $display("FAIL fullpp_drain[%0d] got %h want %h", k, o_data, e); end
            cyc(1'b0, 8'h00, 1'b1);
        end
        n_chk++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL fullpp_drain_empty got %b want 1", o_empty); end
    endtask

    task automatic test_empty;
        cyc(1'b0, 8'h00, 1'b1);
        n_chk++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL udf_empty got %b want 1", o_empty); end
        n_chk++; if (o_count !== 6'd0) begin n_fail++; $display("FAIL udf_count got %0d want 0", o_count); end
`ifdef HRM_IO_FIFO_ERR_EN
        n_chk++; if (o_udf !== 1'b1) begin n_fail++; $display("FAIL udf_flag got %b want 1", o_udf); end
`endif
        cyc(1'b1, 8'h7E, 1'b1);
        n_chk++; if (o_count !== 6'd1) begin n_fail++; $display("FAIL emptypp_count got %0d want 1", o_count); end
        n_chk++; if (o_data !== 8'h7E) begin n_fail++; $display("FAIL emptypp_data got %h want 7e", o_data); end
        n_chk++; if (o_empty !== 1'b0) begin n_fail++; $display("FAIL emptypp_empty got %b want 0", o_empty); end
        cyc(1'b0, 8'h00, 1'b1);
        n_chk++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL emptypp_pop got %b want 1", o_empty); end
    endtask

    task automatic test_back_to_back;
        int nin = 0;
        int nout = 0;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 8; k++) begin cyc(1'b1, 8'(8'hA0 + nin), 1'b0); nin++; end
            for (int k = 0; k < 8; k++) begin
                n_chk++; if (o_data !== 8'(8'hA0 + nout)) begin n_fail++; $display("FAIL wrap[%0d] got %h want %h", nout, o_data, 8'(8'hA0 + nout)); end
                cyc(1'b0, 8'h00, 1'b1);
                nout++;
            end
        end
        n_chk++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", o_empty); end
        for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'hC0 + k), 1'b0);
        i_rst = 1'b1;
        cyc(1'b1, 8'hEE, 1'b1);
        i_rst = 1'b0;
        n_chk++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL midrst_empty got %b want 1", o_empty); end
        n_chk++; if (o_count !== 6'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", o_count); end
`ifdef HRM_IO_FIFO_ERR_EN
        n_chk++; if ({o_ovf, o_udf} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags got %b want 00", {o_ovf, o_udf}); end
`endif
        cyc(1'b1, 8'h5A, 1'b0);
        n_chk++; if (o_data !== 8'h5A) begin n_fail++; $display("FAIL postrst_data got %h want 5a", o_data); end
        n_chk++; if (o_count !== 6'd1) begin n_fail++; $display("FAIL postrst_count got %0d want 1", o_count); end
    endtask

    initial begin
        test_reset;
        test_push_pop;
        test_full;
        test_full_push_pop;
        test_empty;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
